// File: rtl/pokey_audio_channel_out_if.sv
// Signal bundle between the channel timer/poly/AUDC sources and one POKEY audio
// output stage. master drives the controls; slave is the channel output stage.
interface pokey_audio_channel_out_if #(
  parameter int VOL_WIDTH = 4
);
  logic                 enable_pulse;
  logic                 poly4_bit;
  logic                 poly5_bit;
  logic                 poly17_bit;
  logic [7:0]           audc;
  logic                 hp_enable;
  logic                 hp_clock_pulse;
  logic                 init;
  logic                 tone_bit;
  logic                 hp_bit;
  logic [VOL_WIDTH-1:0] vol_out;

  // Strobes are single-cycle qualifiers with no handshake: every cycle in which a
  // strobe is high counts as one event, so a held-high strobe fires every cycle.
  modport master (
    output enable_pulse, poly4_bit, poly5_bit, poly17_bit, audc,
    output hp_enable, hp_clock_pulse, init,
    input  tone_bit, hp_bit, vol_out
  );

  modport slave (
    input  enable_pulse, poly4_bit, poly5_bit, poly17_bit, audc,
    input  hp_enable, hp_clock_pulse, init,
    output tone_bit, hp_bit, vol_out
  );
endinterface

// File: rtl/pokey_audio_channel_out.sv
// POKEY per-channel output stage: distortion-selected tone flip-flop, optional
// high-pass latch, volume-only override and a registered volume level.
module pokey_audio_channel_out #(
  parameter int VOL_WIDTH = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  pokey_audio_channel_out_if.slave        bus
);

  logic                 tone_ff;
  logic                 hp_ff;
  logic [VOL_WIDTH-1:0] vol_q;
  logic                 tone_update;
  logic                 tone_next;
  logic                 eff;

  always_comb begin
    tone_update = 1'b0;
    tone_next   = tone_ff;
    eff         = 1'b0;

    // Poly5 gating applies only when distortion bit 7 is clear.
    tone_update = bus.enable_pulse & (bus.audc[7] | bus.poly5_bit);

    if (bus.audc[5]) begin
      tone_next = ~tone_ff;
    end else if (bus.audc[6]) begin
      tone_next = bus.poly4_bit;
    end else begin
      tone_next = bus.poly17_bit;
    end

    eff = bus.audc[4] | (bus.hp_enable ? (tone_ff ^ hp_ff) : tone_ff);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tone_ff <= 1'b0;
      hp_ff   <= 1'b0;
      vol_q   <= '0;
    end else begin
      // The volume register keeps tracking during init so volume-only still sounds.
      vol_q <= eff ? bus.audc[VOL_WIDTH-1:0] : '0;
      if (bus.init) begin
        tone_ff <= 1'b0;
        hp_ff   <= 1'b0;
      end else begin
        if (tone_update) begin
          tone_ff <= tone_next;
        end
        // Non-blocking read gives the pre-update tone when both strobes coincide.
        if (bus.hp_clock_pulse) begin
          hp_ff <= tone_ff;
        end
      end
    end
  end

  assign bus.tone_bit = tone_ff;
  assign bus.hp_bit   = hp_ff;
  assign bus.vol_out  = vol_q;

endmodule

// File: doc/pokey_audio_channel_out.md
# pokey_audio_channel_out

Per-channel POKEY audio output stage. It sits directly downstream of the channel timer and the poly counters (`pokey_poly_17_9` `bit_out`, plus the poly4 and poly5 bits). On each timer underflow pulse it applies the AUDC distortion selection to update the channel's tone flip-flop. It then applies the optional high-pass latch and the volume-only mode, and registers a 4-bit volume level for the mixer.

## Interface
- `VOL_WIDTH`, default 4: width of the AUDC volume field and of `vol_out`.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `enable_pulse`  in  1  channel timer underflow; one-cycle strobe.
- `poly4_bit`  in  1  current poly4 output.
- `poly5_bit`  in  1  current poly5 output.
- `poly17_bit`  in  1  current poly17/9 output (`bit_out` of the poly block).
- `audc`  in  8  AUDC register:
  - [7:5] distortion,
  - [4] volume-only,
  - [3:0] volume.
- `hp_enable`  in  1  high-pass filter active for this channel (from AUDCTL).
- `hp_clock_pulse`  in  1  partner-channel underflow strobe that clocks the high-pass latch.
- `init`  in  1  SKCTL init state; holds tone and high-pass state cleared.
- `tone_bit`  out  1  current tone flip-flop value.
- `vol_out`  out  `VOL_WIDTH`  registered channel output level.

## Operation
- **Tone flip-flop `tone_ff`**: updates only in a cycle with `enable_pulse`=1 and `init`=0.
  - Gate: if `audc[7]`=0, the update occurs only when `poly5_bit`=1; otherwise `tone_ff` holds. If `audc[7]`=1, every pulse updates.
  - Source when the update occurs:
    - `audc[5]`=1: `tone_ff` toggles (pure tone).
    - `audc[5]`=0, `audc[6]`=1: `tone_ff` loads `poly4_bit`.
    - `audc[5]`=0, `audc[6]`=0: `tone_ff` loads `poly17_bit`.
- **High-pass latch `hp_ff`**: on `hp_clock_pulse`=1 (and `init`=0), `hp_ff` loads the pre-update value of `tone_ff`. It also loads in the same cycle as `enable_pulse`; in that case it samples the old `tone_ff`.
- **Effective bit**:
  - `eff` = `tone_ff` XOR `hp_ff` when `hp_enable`=1, else `tone_ff`.
  - `hp_ff` keeps clocking while `hp_enable`=0, so enabling takes effect with the current latch contents.
- **Volume-only**: if `audc[4]`=1, `eff` is forced to 1 regardless of tone, poly and high-pass state.
- **`vol_out`** register: each cycle it loads `audc[3:0]` if `eff`=1, else 0. No arithmetic is applied; the width is exactly `VOL_WIDTH`.
- **`init`**=1: `tone_ff` and `hp_ff` are cleared and pulses are ignored. `vol_out` continues to track, so volume-only mode still outputs the volume during init.
- **AUDC writes** take effect on the next pulse for distortion bits and on the next cycle for the volume and volume-only bits. No resynchronisation of the tone phase is performed.

## Timing
- **Reset**: `tone_ff`=0, `hp_ff`=0, `tone_bit`=0, `vol_out`=0. Reset dominates `init` and all pulses in the same cycle.
- **Reset mid-operation**: state is cleared at the next edge. Output resumes from zero on the first pulse after reset deasserts.
- **Latency**:
  - `enable_pulse` sampled at edge N → `tone_bit` valid after edge N.
  - `vol_out` reflects it after edge N+1.
  - An `audc[4]` or volume change at edge M reaches `vol_out` after edge M+1.
- **Poly inputs** are sampled only on the edge where `enable_pulse`=1; their values at other times are don't-care.
- **Back-to-back pulses** (`enable_pulse` high on consecutive cycles) each cause an independent update. With pure tone this gives `tone_bit` toggling every cycle.
- **No handshake**: the strobes are assumed single-cycle. A held-high strobe behaves as one strobe per cycle.

## Test plan
- **Reset**: apply reset with `audc`=8'hFF and pulses active → `tone_bit`=0, `vol_out`=0 throughout. After release, the first pulse sets `tone_bit`=1 and `vol_out`=4'hF one cycle later.
- **Pure tone**: `audc`=8'hA8, `hp_enable`=0, pulses every 4 cycles → `tone_bit` toggles per pulse; `vol_out` alternates 4'h8/4'h0 with a 1-cycle lag.
- **Poly5 gating**: `audc`=8'h26, `poly5_bit`=0 on pulses 1 and 3 and 1 on pulses 2 and 4 → `tone_bit` changes only on pulses 2 and 4 (4 pulses → 1 net toggle state change per gated pulse).
- **Noise select**:
  - `audc`=8'hC5, `poly4_bit`=1, `poly17_bit`=0 on a pulse → `tone_bit`=1, `vol_out`=4'h5.
  - `audc`=8'h85 with the same inputs → `tone_bit`=0, `vol_out`=0.
- **High-pass with simultaneous pulses**:
  - `audc`=8'hA3, `hp_enable`=1, `tone_ff`=0.
  - `enable_pulse` and `hp_clock_pulse` together → `tone_bit`=1, `hp_ff`=0, `vol_out`=4'h3.
  - Next `hp_clock_pulse` alone → `hp_ff`=1, `vol_out`=0.
- **Volume-only and init**:
  - `audc`=8'h17 with `init`=1 and pulses active → `vol_out`=4'h7 constant, `tone_bit`=0.
  - `audc`=8'hA7 with `init`=1 → `vol_out`=0, pulses ignored.
